id_stage: RTL
=============

# id_stage

Instruction-decode and operand-fetch stage of the cpu2 pipeline, sitting between fetch and execute. It is the only consumer of the register file's read ports. It splits the 32-bit instruction into fields, drives the two RF read addresses and bypasses the same-cycle writeback value. A 16-entry load scoreboard stalls on pending load destinations, and decoded operands are held in a valid/ready pipeline register toward execute.

## Interface
- `XLEN`, default 32: datapath width.
- `NREG`, default 16: architectural registers; r0 reads as zero.
- `clk  in  1`: clock, rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `if_valid  in  1`: fetch holds an instruction.
- `if_ready  out  1`: stage accepts this cycle (combinational).
- `if_instr  in  32`: instruction word.
- `if_pc  in  XLEN`: instruction address.
- `rf_ra1`, `rf_ra2`  out  5: RF read addresses; bit 4 always 0.
- `rf_rd1`, `rf_rd2`  in  XLEN: RF read data, combinational.
- `wb_we  in  1`: writeback writes the RF this cycle.
- `wb_wa  in  5`: writeback destination.
- `wb_wd  in  XLEN`: writeback data.
- `wb_ld  in  1`: this writeback is load data.
- `flush  in  1`: kill the instruction entering or held in the stage.
- `ex_valid  out  1`: execute operands valid.
- `ex_ready  in  1`: execute consumes this cycle.
- `ex_op  out  6`: opcode.
- `ex_rd  out  5`: destination register.
- `ex_a`, `ex_b`  out  XLEN: source operands.
- `ex_imm  out  XLEN`: sign-extended imm16.
- `ex_pc  out  XLEN`: instruction address.
- `ex_is_load  out  1`: instruction is a load.

## Operation
- Instruction fields: op = [31:26], rd = [25:21], rs1 = [20:16], rs2 = [15:11], imm16 = [15:0].
- All register indices are masked to [3:0].
- rf_ra1 = {0, rs1[3:0]} and rf_ra2 = {0, rs2[3:0]}, driven from if_instr every cycle.
- Operand selection, applied per source:
  - index 0 gives 0;
  - otherwise, if wb_we and wb_wa[3:0] == index, the operand is wb_wd (bypass);
  - otherwise the operand is rf_rd.
- Scoreboard: one pending bit per register.
  - pend_eff = pend & ~clr, where clr[i] = wb_we & wb_ld & (wb_wa[3:0] == i).
- Hazard: if_valid and pend_eff is set for rs1, rs2 or rd, with index ≠ 0. The rd term blocks write-after-write against an in-flight load.
- if_ready = !hazard & !flush & (!ex_valid | ex_ready).
- Accept = if_valid & if_ready.
- Pipeline register:
  - on accept it loads all ex_* fields and sets ex_valid;
  - on ex_ready without accept it clears ex_valid;
  - on flush it clears ex_valid, and flush overrides accept.
- Scoreboard update on accept of a load (op == OP_LD) with rd ≠ 0: the pend[rd] bit is set. If the same bit is also cleared that cycle, set wins.
- Flush does not touch the scoreboard, because issued loads still write back.
- Writeback of a non-load (wb_ld = 0) never clears a pending bit.

## Timing
- Accept to ex_valid: 1 cycle.
- Full throughput of 1 instruction per cycle when there is no hazard and ex_ready = 1.
- Stall: ex_* and ex_valid hold while ex_valid & !ex_ready.
- Load-use: the dependent instruction stalls until the cycle in which wb_ld writes its source. It is accepted that same cycle, with the operand taken from the bypass.
- Reset, asserted asynchronously:
  - ex_valid = 0, all ex_* = 0, scoreboard = 0;
  - if_ready follows its equation, so it is 1 when ex_valid = 0 and no flush is present.
- Reset mid-stall drops the held instruction and forgets all pending loads.

## Structure
- `cpu_pkg`: opcode constants (OP_LD and the rest), field bit positions, NREG, XLEN.
- Sub-module `id_scoreboard`:
  - inputs: set index/enable and clear index/enable;
  - outputs: pend_eff for three query indices;
  - it holds the only state besides the pipeline register.

## Test plan
- Reset, then accept ADD r1, r2, r3 with r2 = 5 and r3 = 7 in the RF → next cycle ex_valid = 1, ex_a = 5, ex_b = 7, ex_rd = 1.
- wb_we = 1, wb_wa = 2, wb_wd = 0x99 in the same cycle as an instruction reading r2 → ex_a = 0x99.
- Load to r4 accepted, then ADD r5, r4, r0 presented → if_ready = 0 until wb_ld writes r4 = 0x1234. It is accepted that cycle with ex_a = 0x1234.
- Instruction with rs1 = 0 while the RF returns 0xFFFF_FFFF → ex_a = 0.
- ex_ready held 0 for 3 cycles → ex_* stable and if_ready = 0; release → the next instruction is accepted the same cycle.
- flush while ex_valid = 1 and a load to r6 is pending → ex_valid = 0 next cycle, and an instruction reading r6 still stalls until wb_ld writes r6.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared cpu2 definitions: datapath sizes, opcode space and instruction field positions.
package cpu_pkg;
  localparam int CPU_XLEN = 32;
  localparam int CPU_NREG = 16;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_LSB  = 21;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 11;
  localparam int IMM_W   = 16;

  typedef enum logic [5:0] {
    OP_ADD = 6'h00,
    OP_SUB = 6'h01,
    OP_AND = 6'h02,
    OP_OR  = 6'h03,
    OP_LD  = 6'h10,
    OP_ST  = 6'h11,
    OP_BEQ = 6'h20
  } opcode_e;
endpackage

// File: rtl/id_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared by load writeback.
module id_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG = CPU_NREG,
  localparam int RIW = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           set_en,
  input  logic [RIW-1:0] set_idx,
  input  logic           clr_en,
  input  logic [RIW-1:0] clr_idx,
  input  logic [RIW-1:0] q0_idx,
  input  logic [RIW-1:0] q1_idx,
  input  logic [RIW-1:0] q2_idx,
  output logic           q0_pend,
  output logic           q1_pend,
  output logic           q2_pend
);
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_eff;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_idx] = 1'b1;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
  end

  // A writeback landing this cycle already releases its register to readers.
  assign pend_eff = pend & ~clr_vec;
  assign q0_pend  = pend_eff[q0_idx];
  assign q1_pend  = pend_eff[q1_idx];
  assign q2_pend  = pend_eff[q2_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= pend_eff | set_vec;
  end
endmodule

// File: rtl/id_stage.sv
// cpu2 decode/operand-fetch stage: field split, RF read with writeback bypass,
// load-hazard stall and a valid/ready register toward execute.
module id_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int NREG = CPU_NREG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_ra1,
  output logic [4:0]      rf_ra2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            wb_ld,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [5:0]      ex_op,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_is_load
);
  localparam int RIW = $clog2(NREG);

  function automatic logic [XLEN-1:0] sel_operand(
    input logic [RIW-1:0]  idx,
    input logic [XLEN-1:0] rd_data,
    input logic            byp_we,
    input logic [RIW-1:0]  byp_idx,
    input logic [XLEN-1:0] byp_data
  );
    if (idx == '0) return '0;
    if (byp_we && (byp_idx == idx)) return byp_data;
    return rd_data;
  endfunction

  function automatic logic [XLEN-1:0] sext_imm(input logic signed [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  logic [5:0]              op;
  logic [RIW-1:0]          rd;
  logic [RIW-1:0]          rs1;
  logic [RIW-1:0]          rs2;
  logic signed [IMM_W-1:0] imm;
  logic                    is_load;
  logic                    pend_rs1, pend_rs2, pend_rd;
  logic                    hazard;
  logic                    accept;

  assign op      = if_instr[OP_MSB:OP_LSB];
  assign rd      = if_instr[RD_LSB +: RIW];
  assign rs1     = if_instr[RS1_LSB +: RIW];
  assign rs2     = if_instr[RS2_LSB +: RIW];
  assign imm     = if_instr[IMM_W-1:0];
  assign is_load = (op == OP_LD);

  assign rf_ra1 = 5'(rs1);
  assign rf_ra2 = 5'(rs2);

  id_scoreboard #(.NREG(NREG)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && is_load && (rd != '0)),
    .set_idx (rd),
    .clr_en  (wb_we && wb_ld),
    .clr_idx (wb_wa[RIW-1:0]),
    .q0_idx  (rs1),
    .q1_idx  (rs2),
    .q2_idx  (rd),
    .q0_pend (pend_rs1),
    .q1_pend (pend_rs2),
    .q2_pend (pend_rd)
  );

  // The rd term keeps a younger writer from overtaking an in-flight load.
  assign hazard = if_valid && (((rs1 != '0) && pend_rs1) ||
                               ((rs2 != '0) && pend_rs2) ||
                               ((rd  != '0) && pend_rd));

  logic            vld_p0;
  logic [5:0]      op_p0;
  logic [4:0]      rd_p0;
  logic [XLEN-1:0] a_p0, b_p0, imm_p0, pc_p0;
  logic            ld_p0;

  assign if_ready = !hazard && !flush && (!vld_p0 || ex_ready);
  assign accept   = if_valid && if_ready;

  // ---- stage boundary: decode -> execute ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      op_p0  <= '0;
      rd_p0  <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      imm_p0 <= '0;
      pc_p0  <= '0;
      ld_p0  <= 1'b0;
    end else begin
      if (flush)         vld_p0 <= 1'b0;
      else if (accept)   vld_p0 <= 1'b1;
      else if (ex_ready) vld_p0 <= 1'b0;
      if (accept) begin
        op_p0  <= op;
        rd_p0  <= 5'(rd);
        a_p0   <= sel_operand(rs1, rf_rd1, wb_we, wb_wa[RIW-1:0], wb_wd);
        b_p0   <= sel_operand(rs2, rf_rd2, wb_we, wb_wa[RIW-1:0], wb_wd);
        imm_p0 <= sext_imm(imm);
        pc_p0  <= if_pc;
        ld_p0  <= is_load;
      end
    end
  end

  assign ex_valid   = vld_p0;
  assign ex_op      = op_p0;
  assign ex_rd      = rd_p0;
  assign ex_a       = a_p0;
  assign ex_b       = b_p0;
  assign ex_imm     = imm_p0;
  assign ex_pc      = pc_p0;
  assign ex_is_load = ld_p0;
endmodule
